// File: rtl/decode_pkg.sv
// Opcode map, format tags and the per-entry decoded field bundle shared by the decode queue.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_R32    = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
    } fmt_e;

    // XLEN-independent part of a queued entry; pc and imm are added by the top.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       rd_we;
        logic       illegal;
    } dec_fields_t;

    function automatic fmt_e classify(input logic [31:0] instr, input logic rv64);
        fmt_e fmt;
        fmt = FMT_ILL;
        if (instr[1:0] == 2'b11 && instr != 32'h0) begin
            case (instr[6:0])
                OP_R:                                fmt = FMT_R;
                OP_R32:                              if (rv64) fmt = FMT_R;
                OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
                OP_IMM32:                            if (rv64) fmt = FMT_I;
                OP_STORE:                            fmt = FMT_S;
                OP_BRANCH:                           fmt = FMT_B;
                OP_LUI, OP_AUIPC:                    fmt = FMT_U;
                OP_JAL:                              fmt = FMT_J;
                default:                             fmt = FMT_ILL;
            endcase
        end
        return fmt;
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_instr;
    logic [XLEN-1:0]              in_pc;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [XLEN-1:0]              out_pc;
    logic [6:0]                   out_opcode;
    logic [4:0]                   out_rd;
    logic [4:0]                   out_rs1;
    logic [4:0]                   out_rs2;
    logic [2:0]                   out_funct3;
    logic [6:0]                   out_funct7;
    logic [XLEN-1:0]              out_imm;
    logic [2:0]                   out_fmt;
    logic                         out_rd_we;
    logic                         out_illegal;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_rd_we, out_illegal, count
    );
endinterface

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO with flush; flush and reset both empty it ahead of any push/pop.
module decode_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; count alone qualifies it.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/decode_queue.sv
// RV32/RV64 decode stage: combinational decode of the fetched word, buffered in a FIFO toward issue.
module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    decode_queue_if.slave bus
);
    localparam logic RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_fields_t     f;
    } decoded_t;

    decoded_t    dec;
    decoded_t    head;
    decoded_t    shown;
    dec_fields_t f;
    fmt_e        fmt;
    logic [31:0] i;
    logic [31:0] imm32;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign i = bus.in_instr;

    always_comb begin
        fmt      = classify(i, RV64);
        f        = '0;
        imm32    = '0;
        f.fmt    = fmt;
        case (fmt)
            FMT_R: begin
                f.rd = i[11:7]; f.rs1 = i[19:15]; f.rs2 = i[24:20];
                f.funct3 = i[14:12]; f.funct7 = i[31:25];
            end
            FMT_I: begin
                f.rd = i[11:7]; f.rs1 = i[19:15]; f.funct3 = i[14:12];
                imm32 = {{20{i[31]}}, i[31:20]};
            end
            FMT_S: begin
                f.rs1 = i[19:15]; f.rs2 = i[24:20]; f.funct3 = i[14:12];
                imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            FMT_B: begin
                f.rs1 = i[19:15]; f.rs2 = i[24:20]; f.funct3 = i[14:12];
                imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            FMT_U: begin
                f.rd = i[11:7];
                imm32 = {i[31:12], 12'b0};
            end
            FMT_J: begin
                f.rd = i[11:7];
                imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            default: f = '0;
        endcase
        f.fmt     = fmt;
        f.illegal = (fmt == FMT_ILL);
        if (fmt != FMT_ILL) f.opcode = i[6:0];
        f.rd_we   = (f.rd != 5'd0);
        dec.pc    = bus.in_pc;
        dec.imm   = XLEN'($signed(imm32));
        dec.f     = f;
    end

    // in_ready comes only from registered count and rst, never from out_ready.
    assign bus.in_ready  = !full && !rst;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    decode_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (decoded_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (push),
        .pop   (pop),
        .wdata (dec),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (bus.count)
    );

    assign shown           = empty ? '0 : head;
    assign bus.out_pc      = shown.pc;
    assign bus.out_imm     = shown.imm;
    assign bus.out_opcode  = shown.f.opcode;
    assign bus.out_rd      = shown.f.rd;
    assign bus.out_rs1     = shown.f.rs1;
    assign bus.out_rs2     = shown.f.rs2;
    assign bus.out_funct3  = shown.f.funct3;
    assign bus.out_funct7  = shown.f.funct7;
    assign bus.out_fmt     = shown.f.fmt;
    assign bus.out_rd_we   = shown.f.rd_we;
    assign bus.out_illegal = shown.f.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: RV32 and RV64 instances share stimulus and are checked against a queue model.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [6:0] OPS [12] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67,
                                        7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32), .DEPTH(DEPTH)) b32();
    decode_queue_if #(.XLEN(64), .DEPTH(DEPTH)) b64();

    decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        we, ill;
    } exp_t;

    item_t       q[$];
    int          errors = 0;
    int          checks = 0;
    logic        in_valid, out_ready, flush;
    logic [31:0] instr;
    logic [63:0] pc;

    // Reference decode from the instruction-set rules, using signed arithmetic for immediates.
    function automatic exp_t ref_dec(input logic [31:0] w, input bit rv64);
        exp_t   e;
        longint si;
        int     k;
        e  = '0;
        si = longint'(signed'(w));
        k  = 6;
        if (w[1:0] == 2'b11 && w != 32'h0) begin
            case (w[6:0])
                7'h33: k = 0;
                7'h3B: k = rv64 ? 0 : 6;
                7'h13, 7'h03, 7'h67, 7'h73: k = 1;
                7'h1B: k = rv64 ? 1 : 6;
                7'h23: k = 2;
                7'h63: k = 3;
                7'h37, 7'h17: k = 4;
                7'h6F: k = 5;
                default: k = 6;
            endcase
        end
        e.fmt = 3'(k);
        if (k == 6) begin
            e.ill = 1'b1;
            return e;
        end
        e.op = w[6:0];
        if (k == 0 || k == 1 || k == 4 || k == 5) e.rd = w[11:7];
        if (k <= 3) begin
            e.rs1 = w[19:15];
            e.f3  = w[14:12];
        end
        if (k == 0 || k == 2 || k == 3) e.rs2 = w[24:20];
        if (k == 0) e.f7 = w[31:25];
        case (k)
            1: e.imm = 64'(si >>> 20);
            2: e.imm = 64'(((si >>> 25) << 5) | longint'(w[11:7]));
            3: e.imm = 64'(((si >>> 31) << 12) | (longint'(w[7]) << 11)
                          | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1));
            4: e.imm = 64'((si >>> 12) << 12);
            5: e.imm = 64'(((si >>> 31) << 20) | (longint'(w[19:12]) << 12)
                          | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1));
            default: e.imm = 64'h0;
        endcase
        e.we = (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int          sel;
        logic [31:0] r;
        sel = $urandom_range(0, 15);
        r   = $urandom;
        if (sel == 0) return 32'h0;
        if (sel == 1) return r;
        r[6:0] = OPS[$urandom_range(0, 11)];
        if (sel == 2) r[1:0] = 2'b10;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        exp_t        e32, e64;
        logic [63:0] hp;
        bit          v, rdy;
        v   = (q.size() != 0);
        rdy = !rst && (q.size() < DEPTH);
        e32 = '0;
        e64 = '0;
        hp  = '0;
        if (v) begin
            e32 = ref_dec(q[0].instr, 1'b0);
            e64 = ref_dec(q[0].instr, 1'b1);
            hp  = q[0].pc;
        end
        chk("in_ready32",  64'(b32.in_ready),    64'(rdy));
        chk("out_valid32", 64'(b32.out_valid),   64'(v));
        chk("count32",     64'(b32.count),       64'(q.size()));
        chk("pc32",        64'(b32.out_pc),      64'(hp[31:0]));
        chk("opcode32",    64'(b32.out_opcode),  64'(e32.op));
        chk("rd32",        64'(b32.out_rd),      64'(e32.rd));
        chk("rs1_32",      64'(b32.out_rs1),     64'(e32.rs1));
        chk("rs2_32",      64'(b32.out_rs2),     64'(e32.rs2));
        chk("funct3_32",   64'(b32.out_funct3),  64'(e32.f3));
        chk("funct7_32",   64'(b32.out_funct7),  64'(e32.f7));
        chk("imm32",       64'(b32.out_imm),     64'(e32.imm[31:0]));
        chk("fmt32",       64'(b32.out_fmt),     64'(e32.fmt));
        chk("rd_we32",     64'(b32.out_rd_we),   64'(e32.we));
        chk("illegal32",   64'(b32.out_illegal), 64'(e32.ill));
        chk("in_ready64",  64'(b64.in_ready),    64'(rdy));
        chk("out_valid64", 64'(b64.out_valid),   64'(v));
        chk("count64",     64'(b64.count),       64'(q.size()));
        chk("pc64",        b64.out_pc,           hp);
        chk("opcode64",    64'(b64.out_opcode),  64'(e64.op));
        chk("rd64",        64'(b64.out_rd),      64'(e64.rd));
        chk("rs1_64",      64'(b64.out_rs1),     64'(e64.rs1));
        chk("rs2_64",      64'(b64.out_rs2),     64'(e64.rs2));
        chk("funct3_64",   64'(b64.out_funct3),  64'(e64.f3));
        chk("funct7_64",   64'(b64.out_funct7),  64'(e64.f7));
        chk("imm64",       b64.out_imm,          e64.imm);
        chk("fmt64",       64'(b64.out_fmt),     64'(e64.fmt));
        chk("rd_we64",     64'(b64.out_rd_we),   64'(e64.we));
        chk("illegal64",   64'(b64.out_illegal), 64'(e64.ill));
    endtask

    // Drive inputs, let them settle, and compare against the model before the edge.
    task automatic pre();
        b32.in_valid  = in_valid;  b64.in_valid  = in_valid;
        b32.in_instr  = instr;     b64.in_instr  = instr;
        b32.in_pc     = pc[31:0];  b64.in_pc     = pc;
        b32.out_ready = out_ready; b64.out_ready = out_ready;
        b32.flush     = flush;     b64.flush     = flush;
        #1;
        check_all();
    endtask

    task automatic post();
        bit push, pop;
        push = in_valid && !rst && (q.size() < DEPTH);
        pop  = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst || flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{instr, pc});
        end
    endtask

    task automatic step();
        pre();
        post();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr = 32'h0; pc = 64'h0;
        pre();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();

        // ADDI, BEQ, LUI back to back with issue always ready
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'hFFF00093; pc = 64'h100;
        step();
        instr = 32'hFE000EE3; pc = 64'h104;
        pre();
        chk("addi_fmt", 64'(b32.out_fmt), 64'(FMT_I));
        chk("addi_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
        chk("addi_rd",  64'(b32.out_rd),  64'd1);
        post();
        instr = 32'h123452B7; pc = 64'h108;
        pre();
        chk("beq_imm32", 64'(b32.out_imm), 64'hFFFFFFFC);
        chk("beq_imm64", b64.out_imm,      64'hFFFFFFFFFFFFFFFC);
        chk("beq_rd_we", 64'(b32.out_rd_we), 64'd0);
        post();
        in_valid = 1'b0;
        pre();
        chk("lui_fmt", 64'(b32.out_fmt), 64'(FMT_U));
        chk("lui_imm", 64'(b32.out_imm), 64'h12345000);
        chk("lui_rd",  64'(b32.out_rd),  64'd5);
        post();

        // Fill to full, then drain while still pushing
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr = 32'h00000093 | (32'(k) << 20); pc = 64'h200 + 64'(4 * k);
            if (k == 4) begin
                pre();
                chk("full_ready", 64'(b32.in_ready), 64'd0);
                chk("full_count", 64'(b32.count),    64'd4);
                post();
            end else step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            instr = 32'h00A00113 | (32'(k) << 7); pc = 64'h300 + 64'(4 * k);
            pre();
            if (k > 0) chk("steady_count", 64'(b32.count), 64'd3);
            post();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Flush while full with a beat offered, then flush with a beat accepted
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = 32'h00000013; pc = 64'h400 + 64'(4 * k);
            step();
        end
        flush = 1'b1; instr = 32'h7FF00093; pc = 64'hDEAD0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        pre();
        chk("flush_count", 64'(b32.count),     64'd0);
        chk("flush_valid", 64'(b32.out_valid), 64'd0);
        post();
        in_valid = 1'b1; instr = 32'h00000013; pc = 64'h500;
        step();
        flush = 1'b1; instr = 32'h00100093; pc = 64'h504;
        pre();
        chk("flush_ready", 64'(b32.in_ready), 64'd1);
        post();
        flush = 1'b0; in_valid = 1'b0;
        step();

        // Illegal encodings keep their pc
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0; pc = 64'h600;
        step();
        instr = 32'h00000012; pc = 64'h604;
        pre();
        chk("ill0_flag", 64'(b32.out_illegal), 64'd1);
        chk("ill0_pc",   64'(b32.out_pc),      64'h600);
        post();
        in_valid = 1'b0;
        pre();
        chk("ill12_fmt", 64'(b32.out_fmt), 64'(FMT_ILL));
        chk("ill12_imm", 64'(b32.out_imm), 64'd0);
        post();

        // Reset with three entries queued
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = 32'h00208033; pc = 64'h700 + 64'(4 * k);
            step();
        end
        rst = 1'b1;
        pre();
        chk("rst_ready", 64'(b32.in_ready), 64'd0);
        post();
        rst = 1'b0; in_valid = 1'b0;
        pre();
        chk("post_rst_count", 64'(b32.count),     64'd0);
        chk("post_rst_ready", 64'(b32.in_ready),  64'd1);
        post();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            instr     = rand_instr();
            pc        = {32'($urandom), 32'($urandom)};
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
